aes_stream_ctrl: RTL
====================

# aes_stream_ctrl

Memory-mapped, multi-block AES stream controller: the next-generation register front end for the AES-128 core. A CPU can queue up to DEPTH plaintext or ciphertext blocks in an input FIFO and collect results from an output FIFO. The block performs ECB, CBC and CTR chaining itself, driving a single-block AES core through a start/done handshake.

## Interface
- DEPTH, 4: entries per FIFO, in 128-bit blocks; power of two, 2..16.
- CTR_W, 32: low IV bits incremented in CTR mode; 8..128.
- clk  in  1  clock; one clock domain, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  bus access this cycle.
- wen  in  1  1 = write, 0 = read.
- addr  in  7  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational from addr.
- core_start  out  1  one-cycle start pulse to the AES core.
- core_encdec  out  1  1 = encrypt.
- core_key  out  128  key to the core; stable while busy.
- core_din  out  128  block to the core; stable until core_done.
- core_dout  in  128  core result; valid with core_done.
- core_done  in  1  one-cycle completion pulse.

## Operation
- Register map:
  - 0x00 CTRL: bit0 soft reset, self-clearing; bit1 enable; bit2 encdec; bits4:3 mode (00 ECB, 01 CBC, 10 CTR). A write of mode 11 leaves the mode field unchanged.
  - 0x04–0x10 KEYW0..3, write-only; reads return 0.
  - 0x14–0x20 PTW0..3.
  - 0x24–0x30 IVW0..3; reads return the live chain register.
  - 0x34–0x40 CTW0..3; reads return the output FIFO head.
  - 0x44 STATUS.
  - 0x48 COUNT.
  - Unmapped addresses read 0.
- Word order is the same for every 128-bit register: W0 = [127:96], W3 = [31:0].
- Writing PTW0 pushes the staged {PTW0..3} into the input FIFO. Writing PTW1..3 only stages.
- A read of CTW0 (valid & !wen) pops the output FIFO at the clock edge ending that cycle.
- STATUS bits:
  - b0 out_valid (output FIFO non-empty)
  - b1 busy (FSM ≠ IDLE)
  - b2 in_full
  - b3 out_full
  - b4 in_overflow, sticky
  - b5 out_underflow, sticky
  - Writing 1 to b4 or b5 clears that bit.
- COUNT fields: [7:0] input FIFO occupancy, [15:8] output FIFO occupancy, [31:16] completed blocks (wraps at 2^16).
- Writes to KEY, IV, or CTRL bits 4:2 are ignored while busy. Enable and soft reset are always writable.
- FSM:
  - IDLE→LOAD when enable, input FIFO non-empty and output FIFO not full.
  - LOAD→WAIT: pop the input FIFO, register core_din, pulse core_start.
  - WAIT→IDLE on core_done: push the result, update the chain register, increment the completed-block count.
- Datapath per mode (X = popped block, C = chain register):
  - ECB: din = X; out = dout.
  - CBC encrypt: din = X^C; out = dout; C ← dout.
  - CBC decrypt: din = X; out = dout^C; C ← X (X held from the pop).
  - CTR: din = C; core_encdec forced to 1; out = X^dout; C[CTR_W-1:0] += 1 mod 2^CTR_W; upper bits unchanged.
- Boundary rules:
  - Push into a full input FIFO: block dropped, in_overflow set.
  - CTW0 read with the output FIFO empty: no state change, out_underflow set.
  - A push and an FSM pop in the same cycle are both performed; occupancy is unchanged.
  - A pop and a result push in the same cycle are both performed.
  - core_done outside WAIT is ignored.
- Soft reset (or clearing enable while in WAIT does nothing special: the op completes):
  - Returns the FSM to IDLE.
  - Empties both FIFOs.
  - Clears COUNT, sticky flags and the enable bit.
  - Keeps key, IV and mode.
  - A core_done from an abandoned operation is ignored.

## Timing
- Reset values:
  - rdata 0 for any read issued in reset.
  - core_start 0, core_encdec 0, core_key 0, core_din 0.
  - All registers and flags 0; FSM in IDLE; FIFOs empty.
- A PTW0 write at edge N with enable set and the FSM idle:
  - LOAD at N+1.
  - core_start high for exactly the cycle after N+2.
- core_done sampled at edge M gives:
  - out_valid = 1 from M.
  - busy = 0 from M.
  - The next LOAD at M+1 if queued.
- Throughput: 2 + core latency cycles per block.
- The core must tolerate core_done at the earliest one cycle after core_start.
- rdata reflects writes from the previous edge, so there is no read-during-write bypass.

## Test plan
- ECB encrypt vector:
  - Stimulus: key fb0b38bcad60b76c73377dfd9ce5692f, PT 16b576b600a49804d81267644b80e292, CTRL=0x6.
  - Required: CT 33b661a74d164dc7b811f54fe5a5832c; COUNT[31:16]=1.
- ECB queued blocks:
  - Stimulus: the above PT plus PT fb8587bdac1c369369173bceb2ed4785, both pushed with enable=0, then enable set.
  - Required: CT 33b661a7… then 2287d7fc410a4e2059c15b4a2a2b3375, in that order.
- CBC with IV=0 and CTR:
  - CBC: the first CT equals the ECB CT; after a CBC encrypt then decrypt round trip (IV reset to 0), the original PTs are returned.
  - CTR: with IV low word ffffffff, after one block the IV reads …00000000 and upper words are unchanged.
- Overflow and underflow:
  - Stimulus: DEPTH=4, enable=0, push 5 blocks.
  - Required: STATUS b2=1, b4=1; COUNT[7:0]=4.
  - Then a CTW0 read sets b5.
  - Writing 0x30 to STATUS clears b4 and b5.
- Soft reset mid-operation:
  - Stimulus: soft reset in WAIT, with a stub core delaying core_done 20 cycles.
  - Required: busy=0, both FIFOs empty, the late done ignored, key retained; the next block still encrypts correctly.
- Asynchronous reset:
  - Stimulus: reset asserted mid-WAIT between clock edges.
  - Required: outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/aes_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module : aes_stream_ctrl
// Brief  : Memory-mapped AES stream front end with in/out block FIFOs and
//          ECB/CBC/CTR chaining around a single-block AES core.
// Rev    : 1.0  initial release
// ============================================================================
module aes_stream_ctrl #(
    parameter int DEPTH = 4,
    parameter int CTR_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid,
    input  logic         wen,
    input  logic [6:0]   addr,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         core_start,
    output logic         core_encdec,
    output logic [127:0] core_key,
    output logic [127:0] core_din,
    input  logic [127:0] core_dout,
    input  logic         core_done
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [127:0] c_ctr_mask = ~({128{1'b1}} << CTR_W);
    localparam logic [1:0] c_mode_cbc = 2'b01;
    localparam logic [1:0] c_mode_ctr = 2'b10;
    localparam logic [4:0] c_w_ctrl   = 5'd0;
    localparam logic [4:0] c_w_pt0    = 5'd5;
    localparam logic [4:0] c_w_ct0    = 5'd13;
    localparam logic [4:0] c_w_status = 5'd17;
    localparam logic [4:0] c_w_count  = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [127:0]        r_key, r_iv, r_pt, r_x, r_core_din;
    logic                r_enable, r_encdec, r_core_start, r_core_encdec;
    logic [1:0]          r_mode;
    logic [127:0]        r_in_mem  [DEPTH];
    logic [127:0]        r_out_mem [DEPTH];
    logic [c_aw-1:0]     r_in_wp, r_in_rp, r_out_wp, r_out_rp;
    logic [c_cw-1:0]     r_in_cnt, r_out_cnt;
    logic                r_in_ovf, r_out_unf, r_abandon;
    logic [15:0]         r_done_cnt;

    logic                w_wr, w_rd, w_al, w_blk, w_busy, w_soft, w_ctrl_wr, w_status_wr;
    logic [4:0]          w_word, w_wm1;
    logic [1:0]          w_grp, w_sub;
    logic [6:0]          w_hi;
    logic                w_in_full, w_in_empty, w_out_full, w_out_empty;
    logic                w_in_push_req, w_in_push, w_in_pop;
    logic                w_out_pop_req, w_out_pop, w_out_push;
    logic [127:0]        w_x, w_head, w_din, w_result, w_chain_next;

    assign w_wr        = valid & wen;
    assign w_rd        = valid & ~wen;
    assign w_word      = addr[6:2];
    assign w_al        = (addr[1:0] == 2'b00);
    assign w_wm1       = w_word - 5'd1;
    assign w_grp       = w_wm1[3:2];
    assign w_sub       = w_wm1[1:0];
    assign w_hi        = 7'd127 - {w_sub, 5'd0};
    assign w_blk       = (w_word != 5'd0) && (w_word <= 5'd16);
    assign w_busy      = (r_state != S_IDLE);
    assign w_ctrl_wr   = w_wr && w_al && (w_word == c_w_ctrl);
    assign w_status_wr = w_wr && w_al && (w_word == c_w_status);
    assign w_soft      = w_ctrl_wr && wdata[0];

    assign w_in_full     = (r_in_cnt == c_cw'(DEPTH));
    assign w_in_empty    = (r_in_cnt == '0);
    assign w_out_full    = (r_out_cnt == c_cw'(DEPTH));
    assign w_out_empty   = (r_out_cnt == '0);
    assign w_in_push_req = w_wr && w_al && (w_word == c_w_pt0);
    assign w_in_push     = w_in_push_req && !w_in_full;
    assign w_in_pop      = (r_state == S_LOAD);
    assign w_out_pop_req = w_rd && w_al && (w_word == c_w_ct0);
    assign w_out_pop     = w_out_pop_req && !w_out_empty;
    assign w_out_push    = (r_state == S_WAIT) && core_done;
    assign w_x           = r_in_mem[r_in_rp];
    assign w_head        = r_out_mem[r_out_rp];

    // w_din is consumed in LOAD (fresh FIFO head); result/chain in WAIT (held block)
    always_comb begin
        w_din        = w_x;
        w_result     = core_dout;
        w_chain_next = r_iv;
        case (r_mode)
            c_mode_cbc: begin
                if (r_encdec) begin
                    w_din        = w_x ^ r_iv;
                    w_chain_next = core_dout;
                end else begin
                    w_result     = core_dout ^ r_iv;
                    w_chain_next = r_x;
                end
            end
            c_mode_ctr: begin
                w_din        = r_iv;
                w_result     = r_x ^ core_dout;
                w_chain_next = (r_iv & ~c_ctr_mask) | ((r_iv + 128'd1) & c_ctr_mask);
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        if (w_al) begin
            if (w_word == c_w_ctrl) begin
                rdata = {27'd0, r_mode, r_encdec, r_enable, 1'b0};
            end else if (w_blk) begin
                case (w_grp)
                    2'd1:    rdata = r_pt[w_hi -: 32];
                    2'd2:    rdata = r_iv[w_hi -: 32];
                    2'd3:    rdata = w_head[w_hi -: 32];
                    default: rdata = 32'd0;
                endcase
            end else if (w_word == c_w_status) begin
                rdata = {26'd0, r_out_unf, r_in_ovf, w_out_full, w_in_full, w_busy, !w_out_empty};
            end else if (w_word == c_w_count) begin
                rdata = {r_done_cnt, {(8 - c_cw){1'b0}}, r_out_cnt, {(8 - c_cw){1'b0}}, r_in_cnt};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_key         <= '0;
            r_iv          <= '0;
            r_pt          <= '0;
            r_x           <= '0;
            r_core_din    <= '0;
            r_enable      <= 1'b0;
            r_encdec      <= 1'b0;
            r_mode        <= 2'b00;
            r_core_start  <= 1'b0;
            r_core_encdec <= 1'b0;
            r_in_wp       <= '0;
            r_in_rp       <= '0;
            r_out_wp      <= '0;
            r_out_rp      <= '0;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_in_ovf      <= 1'b0;
            r_out_unf     <= 1'b0;
            r_abandon     <= 1'b0;
            r_done_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_in_mem[i]  <= '0;
                r_out_mem[i] <= '0;
            end
        end else begin
            r_core_start <= 1'b0;
            if (r_abandon && core_done) r_abandon <= 1'b0;

            if (w_ctrl_wr && !wdata[0]) begin
                r_enable <= wdata[1];
                if (!w_busy) begin
                    r_encdec <= wdata[2];
                    if (wdata[4:3] != 2'b11) r_mode <= wdata[4:3];
                end
            end
            if (w_wr && w_al && w_blk) begin
                case (w_grp)
                    2'd0:    if (!w_busy) r_key[w_hi -: 32] <= wdata;
                    2'd1:    r_pt[w_hi -: 32] <= wdata;
                    2'd2:    if (!w_busy) r_iv[w_hi -: 32] <= wdata;
                    default: ;
                endcase
            end

            if (w_in_push_req && w_in_full)        r_in_ovf <= 1'b1;
            else if (w_status_wr && wdata[4])      r_in_ovf <= 1'b0;
            if (w_out_pop_req && w_out_empty)      r_out_unf <= 1'b1;
            else if (w_status_wr && wdata[5])      r_out_unf <= 1'b0;

            if (w_in_push) begin
                r_in_mem[r_in_wp] <= {wdata, r_pt[95:0]};
                r_in_wp           <= r_in_wp + 1'b1;
            end
            if (w_out_pop) r_out_rp <= r_out_rp + 1'b1;
            r_in_cnt  <= r_in_cnt + c_cw'(w_in_push) - c_cw'(w_in_pop);
            r_out_cnt <= r_out_cnt + c_cw'(w_out_push) - c_cw'(w_out_pop);

            case (r_state)
                S_IDLE: begin
                    if (r_enable && !w_in_empty && !w_out_full && !r_abandon) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_in_rp       <= r_in_rp + 1'b1;
                    r_x           <= w_x;
                    r_core_din    <= w_din;
                    r_core_encdec <= r_encdec | (r_mode == c_mode_ctr);
                    r_core_start  <= 1'b1;
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_out_mem[r_out_wp] <= w_result;
                        r_out_wp            <= r_out_wp + 1'b1;
                        r_iv                <= w_chain_next;
                        r_done_cnt          <= r_done_cnt + 16'd1;
                        r_state             <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Soft reset wins over everything above; an in-flight core op is
            // remembered so its late done cannot be mistaken for a new block.
            if (w_soft) begin
                r_state      <= S_IDLE;
                r_core_start <= 1'b0;
                r_enable     <= 1'b0;
                r_in_wp      <= '0;
                r_in_rp      <= '0;
                r_out_wp     <= '0;
                r_out_rp     <= '0;
                r_in_cnt     <= '0;
                r_out_cnt    <= '0;
                r_in_ovf     <= 1'b0;
                r_out_unf    <= 1'b0;
                r_done_cnt   <= '0;
                if (r_state == S_WAIT && !core_done) r_abandon <= 1'b1;
            end
        end
    end

    assign core_start  = r_core_start;
    assign core_encdec = r_core_encdec;
    assign core_key    = r_key;
    assign core_din    = r_core_din;

endmodule
`default_nettype wire
